// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for a pipelined RV32I datapath: tracks EX and post-EX slots,
// drives stage load/flush controls and EX operand forwarding. Optional PIPELINE_HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_W     = 5,
    parameter int unsigned FWD_DEPTH = 2,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_wr_en,
    input  logic             id_is_load,
    input  logic             id_mem_op,
    input  logic             ex_br_taken,
    input  logic             imem_resp,
    input  logic             dmem_resp,
    output logic             ld_pc,
    output logic             ld_if_id,
    output logic             ld_id_ex,
    output logic             ld_ex_mem,
    output logic             ld_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [SEL_W-1:0] fwd_rs1_sel,
    output logic [SEL_W-1:0] fwd_rs2_sel
`ifdef PIPELINE_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_luse_cnt,
    output logic [CNT_W-1:0] perf_dstall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

    localparam logic [2:0] CASE_RST    = 3'd0;
    localparam logic [2:0] CASE_DSTALL = 3'd1;
    localparam logic [2:0] CASE_BR     = 3'd2;
    localparam logic [2:0] CASE_LUSE   = 3'd3;
    localparam logic [2:0] CASE_IMISS  = 3'd4;
    localparam logic [2:0] CASE_NORM   = 3'd5;

    if (FWD_DEPTH < 2 || FWD_DEPTH > 6) begin : g_depth_chk
        $error("FWD_DEPTH out of range 2..6");
    end
    if (CNT_W < 1) begin : g_cnt_chk
        $error("CNT_W must be at least 1");
    end

    // EX slot
    logic             e_valid_q;
    logic [REG_W-1:0] e_rs1_q;
    logic [REG_W-1:0] e_rs2_q;
    logic             e_uses_rs1_q;
    logic             e_uses_rs2_q;
    logic [REG_W-1:0] e_rd_q;
    logic             e_wr_en_q;
    logic             e_is_load_q;
    logic             e_mem_op_q;

    // Post-EX slots, index 1 = MEM ... FWD_DEPTH = WB
    logic [FWD_DEPTH:1]            s_valid_q;
    logic [FWD_DEPTH:1][REG_W-1:0] s_rd_q;
    logic [FWD_DEPTH:1]            s_wr_en_q;
    logic [FWD_DEPTH:1]            s_mem_op_q;

    // A branch seen during a data stall is remembered until the stall clears
    logic br_pend_q;
    logic br_eff;

    logic       dstall;
    logic       luse;
    logic       rs1_hit;
    logic       rs2_hit;
    logic [2:0] sel;

    assign dstall  = s_valid_q[1] & s_mem_op_q[1] & ~dmem_resp;
    assign br_eff  = ex_br_taken | br_pend_q;
    assign rs1_hit = id_uses_rs1 & (id_rs1 == e_rd_q);
    assign rs2_hit = id_uses_rs2 & (id_rs2 == e_rd_q);
    assign luse    = e_valid_q & e_is_load_q & e_wr_en_q & (e_rd_q != '0) & id_valid &
                     (rs1_hit | rs2_hit);

    always_comb begin
        sel = CASE_NORM;
        if (rst) begin
            sel = CASE_RST;
        end else if (dstall) begin
            sel = CASE_DSTALL;
        end else if (br_eff) begin
            sel = CASE_BR;
        end else if (luse) begin
            sel = CASE_LUSE;
        end else if (!imem_resp) begin
            sel = CASE_IMISS;
        end
    end

    always_comb begin
        ld_pc       = 1'b1;
        ld_if_id    = 1'b1;
        ld_id_ex    = 1'b1;
        ld_ex_mem   = 1'b1;
        ld_mem_wb   = 1'b1;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        unique case (sel)
            CASE_RST: begin
                ld_pc       = 1'b0;
                ld_if_id    = 1'b0;
                ld_id_ex    = 1'b0;
                ld_ex_mem   = 1'b0;
                ld_mem_wb   = 1'b0;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
            CASE_DSTALL: begin
                ld_pc     = 1'b0;
                ld_if_id  = 1'b0;
                ld_id_ex  = 1'b0;
                ld_ex_mem = 1'b0;
                ld_mem_wb = 1'b0;
            end
            CASE_BR: begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
            CASE_LUSE: begin
                ld_pc       = 1'b0;
                ld_if_id    = 1'b0;
                flush_id_ex = 1'b1;
            end
            CASE_IMISS: begin
                ld_pc       = 1'b0;
                flush_if_id = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Descending scan so the youngest (lowest k) matching slot wins
    always_comb begin
        fwd_rs1_sel = '0;
        fwd_rs2_sel = '0;
        if (!rst && e_valid_q) begin
            for (int k = int'(FWD_DEPTH); k >= 1; k--) begin
                if (s_valid_q[k] && s_wr_en_q[k]) begin
                    if (e_uses_rs1_q && (e_rs1_q != '0) && (s_rd_q[k] == e_rs1_q)) begin
                        fwd_rs1_sel = SEL_W'(k);
                    end
                    if (e_uses_rs2_q && (e_rs2_q != '0) && (s_rd_q[k] == e_rs2_q)) begin
                        fwd_rs2_sel = SEL_W'(k);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid_q <= 1'b0;
            s_valid_q <= '0;
            br_pend_q <= 1'b0;
        end else if (dstall) begin
            br_pend_q <= br_pend_q | ex_br_taken;
        end else begin
            for (int k = int'(FWD_DEPTH); k >= 2; k--) begin
                s_valid_q[k] <= s_valid_q[k-1];
            end
            s_valid_q[1] <= e_valid_q;
            e_valid_q    <= id_valid & ~flush_id_ex;
            br_pend_q    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !dstall) begin
            for (int k = int'(FWD_DEPTH); k >= 2; k--) begin
                s_rd_q[k]     <= s_rd_q[k-1];
                s_wr_en_q[k]  <= s_wr_en_q[k-1];
                s_mem_op_q[k] <= s_mem_op_q[k-1];
            end
            s_rd_q[1]     <= e_rd_q;
            s_wr_en_q[1]  <= e_wr_en_q;
            s_mem_op_q[1] <= e_mem_op_q;
            e_rs1_q       <= id_rs1;
            e_rs2_q       <= id_rs2;
            e_uses_rs1_q  <= id_uses_rs1;
            e_uses_rs2_q  <= id_uses_rs2;
            e_rd_q        <= id_rd;
            e_wr_en_q     <= id_wr_en;
            e_is_load_q   <= id_is_load;
            e_mem_op_q    <= id_mem_op;
        end
    end

`ifdef PIPELINE_HAZARD_PERF_EN
    logic [CNT_W-1:0] luse_cnt_q, luse_cnt_d;
    logic [CNT_W-1:0] dstall_cnt_q, dstall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        luse_cnt_d   = luse_cnt_q + CNT_W'(sel == CASE_LUSE);
        dstall_cnt_d = dstall_cnt_q + CNT_W'(sel == CASE_DSTALL);
        flush_cnt_d  = flush_cnt_q + CNT_W'(sel == CASE_BR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            luse_cnt_q   <= '0;
            dstall_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            luse_cnt_q   <= luse_cnt_d;
            dstall_cnt_q <= dstall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign perf_luse_cnt   = luse_cnt_q;
    assign perf_dstall_cnt = dstall_cnt_q;
    assign perf_flush_cnt  = flush_cnt_q;
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed instruction sequences, expected
// control/forwarding values queued per cycle and checked by a separate monitor.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       mem;
    } ins_t;

    typedef struct {
        string      name;
        logic [6:0] ctl;
        logic [1:0] f1;
        logic [1:0] f2;
        bit         chk_perf;
        int         p_luse;
        int         p_dst;
        int         p_fl;
    } exp_t;

    // {ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb, flush_if_id, flush_id_ex}
    localparam logic [6:0] NORM  = 7'b11111_00;
    localparam logic [6:0] RSTV  = 7'b00000_11;
    localparam logic [6:0] DST   = 7'b00000_00;
    localparam logic [6:0] BRF   = 7'b11111_11;
    localparam logic [6:0] LU    = 7'b00111_01;
    localparam logic [6:0] IMISS = 7'b01111_10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    ins_t       id  = '0;
    logic       ex_br_taken = 1'b0;
    logic       imem_resp = 1'b1;
    logic       dmem_resp = 1'b1;
    logic       ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb;
    logic       flush_if_id, flush_id_ex;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
`ifdef PIPELINE_HAZARD_PERF_EN
    logic [31:0] perf_luse_cnt, perf_dstall_cnt, perf_flush_cnt;
`endif

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_perf = 1'b0;
    int   p_luse = 0, p_dst = 0, p_fl = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_W    (5),
        .FWD_DEPTH(2),
        .CNT_W    (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id.v),
        .id_rs1     (id.rs1),
        .id_rs2     (id.rs2),
        .id_uses_rs1(id.u1),
        .id_uses_rs2(id.u2),
        .id_rd      (id.rd),
        .id_wr_en   (id.wr),
        .id_is_load (id.ld),
        .id_mem_op  (id.mem),
        .ex_br_taken(ex_br_taken),
        .imem_resp  (imem_resp),
        .dmem_resp  (dmem_resp),
        .ld_pc      (ld_pc),
        .ld_if_id   (ld_if_id),
        .ld_id_ex   (ld_id_ex),
        .ld_ex_mem  (ld_ex_mem),
        .ld_mem_wb  (ld_mem_wb),
        .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex),
        .fwd_rs1_sel(fwd_rs1_sel),
        .fwd_rs2_sel(fwd_rs2_sel)
`ifdef PIPELINE_HAZARD_PERF_EN
        ,
        .perf_luse_cnt  (perf_luse_cnt),
        .perf_dstall_cnt(perf_dstall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    function automatic ins_t alu(int rd, int rs1, int rs2);
        ins_t i = '0;
        i.v = 1'b1; i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
        i.u1 = 1'b1; i.u2 = 1'b1; i.wr = 1'b1;
        return i;
    endfunction

    function automatic ins_t alui(int rd, int rs1);
        ins_t i = alu(rd, rs1, 0);
        i.u2 = 1'b0;
        return i;
    endfunction

    function automatic ins_t lw(int rd, int rs1);
        ins_t i = alui(rd, rs1);
        i.ld = 1'b1; i.mem = 1'b1;
        return i;
    endfunction

    function automatic ins_t sw(int rs1, int rs2);
        ins_t i = alu(0, rs1, rs2);
        i.wr = 1'b0; i.mem = 1'b1;
        return i;
    endfunction

    function automatic ins_t bxx(int rs1, int rs2);
        ins_t i = alu(0, rs1, rs2);
        i.wr = 1'b0;
        return i;
    endfunction

    localparam ins_t NOP = '0;

    task automatic cyc(input string nm, input logic r, input ins_t i, input logic br,
                       input logic im, input logic dm, input logic [6:0] ctl,
                       input logic [1:0] f1, input logic [1:0] f2);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id = i; ex_br_taken = br; imem_resp = im; dmem_resp = dm;
        e.name = nm; e.ctl = ctl; e.f1 = f1; e.f2 = f2;
        e.chk_perf = chk_perf; e.p_luse = p_luse; e.p_dst = p_dst; e.p_fl = p_fl;
        chk_perf = 1'b0;
        sb.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents its controls, compare against the queued entry
    always @(negedge clk) begin
        exp_t e;
        logic [6:0] act;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            act = {ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb, flush_if_id, flush_id_ex};
            n_cmp++;
            if (act !== e.ctl) begin
                n_bad++;
                $display("FAIL %s ctl: got %b want %b", e.name, act, e.ctl);
            end
            n_cmp++;
            if (fwd_rs1_sel !== e.f1) begin
                n_bad++;
                $display("FAIL %s fwd_rs1: got %0d want %0d", e.name, fwd_rs1_sel, e.f1);
            end
            n_cmp++;
            if (fwd_rs2_sel !== e.f2) begin
                n_bad++;
                $display("FAIL %s fwd_rs2: got %0d want %0d", e.name, fwd_rs2_sel, e.f2);
            end
`ifdef PIPELINE_HAZARD_PERF_EN
            if (e.chk_perf) begin
                n_cmp++;
                if (perf_luse_cnt !== 32'(e.p_luse) || perf_dstall_cnt !== 32'(e.p_dst) ||
                    perf_flush_cnt !== 32'(e.p_fl)) begin
                    n_bad++;
                    $display("FAIL %s perf: got %0d/%0d/%0d want %0d/%0d/%0d", e.name,
                             perf_luse_cnt, perf_dstall_cnt, perf_flush_cnt,
                             e.p_luse, e.p_dst, e.p_fl);
                end
            end
`endif
        end
    end

    // A load in MEM must never match a source of the instruction in EX
    always @(negedge clk) begin
        if (!rst && dut.s_valid_q[1] && dut.s_mem_op_q[1] && dut.s_wr_en_q[1] &&
            dut.s_rd_q[1] != 5'd0) begin
            n_cmp++;
            if (dut.e_valid_q &&
                ((dut.e_uses_rs1_q && dut.e_rs1_q == dut.s_rd_q[1]) ||
                 (dut.e_uses_rs2_q && dut.e_rs2_q == dut.s_rd_q[1]))) begin
                n_bad++;
                $display("FAIL slot1_load_hazard: load rd %0d matches EX source", dut.s_rd_q[1]);
            end
        end
    end

    initial begin
        cyc("rst0", 1, NOP, 0, 1, 1, RSTV, 0, 0);
        cyc("rst1", 1, NOP, 0, 1, 1, RSTV, 0, 0);
        // ALU chain
        cyc("alu_add",   0, alu(5, 1, 2), 0, 1, 0, NORM, 0, 0);
        cyc("alu_sub",   0, alu(7, 5, 5), 0, 1, 0, NORM, 0, 0);
        cyc("alu_fwd1",  0, NOP,          0, 1, 0, NORM, 1, 1);
        // Load-use
        cyc("lu_lw",     0, lw(5, 1),     0, 1, 1, NORM, 0, 0);
        cyc("lu_stall",  0, alu(6, 5, 1), 0, 1, 1, LU,   0, 0);
        cyc("lu_resume", 0, alu(6, 5, 1), 0, 1, 1, NORM, 0, 0);
        cyc("lu_fwd2",   0, NOP,          0, 1, 1, NORM, 2, 0);
        // x0 guard
        cyc("x0_addi",   0, alui(0, 0),   0, 1, 1, NORM, 0, 0);
        cyc("x0_add",    0, alu(3, 0, 0), 0, 1, 1, NORM, 0, 0);
        cyc("x0_nofwd",  0, lw(0, 2),     0, 1, 1, NORM, 0, 0);
        cyc("x0_noluse", 0, alu(4, 0, 0), 0, 1, 1, NORM, 0, 0);
        cyc("x0_after",  0, NOP,          0, 1, 1, NORM, 0, 0);
        // Data stall behind a store
        cyc("ds_add10",  0, alu(10, 1, 2),  0, 1, 1, NORM, 0, 0);
        cyc("ds_sw",     0, sw(3, 8),       0, 1, 1, NORM, 0, 0);
        cyc("ds_add11",  0, alu(11, 10, 1), 0, 1, 1, NORM, 0, 0);
        for (int n = 0; n < 3; n++) begin
            cyc("ds_freeze", 0, alu(12, 11, 11), 0, 1, 0, DST, 2, 0);
        end
        cyc("ds_release", 0, alu(12, 11, 11), 0, 1, 1, NORM, 2, 0);
        cyc("ds_next",    0, NOP,             0, 1, 1, NORM, 1, 1);
        // Branch beats load-use
        cyc("bl_lw",     0, lw(13, 1),        0, 1, 1, NORM, 0, 0);
        cyc("bl_branch", 0, alu(14, 13, 13),  1, 1, 1, BRF,  0, 0);
        cyc("bl_after",  0, NOP,              0, 1, 1, NORM, 0, 0);
        // Branch held across a data stall
        cyc("bd_sw",     0, sw(1, 2),     0, 1, 1, NORM, 0, 0);
        cyc("bd_beq",    0, bxx(13, 2),   0, 1, 1, NORM, 0, 0);
        cyc("bd_frz0",   0, lw(15, 1),    1, 1, 0, DST,  0, 0);
        cyc("bd_frz1",   0, lw(15, 1),    0, 1, 0, DST,  0, 0);
        cyc("bd_flush",  0, lw(15, 1),    0, 1, 1, BRF,  0, 0);
        cyc("bd_after",  0, NOP,          0, 1, 1, NORM, 0, 0);
        // Instruction memory miss
        cyc("im_miss",   0, alu(16, 1, 2),  0, 0, 1, IMISS, 0, 0);
        cyc("im_resume", 0, alu(17, 16, 0), 0, 1, 1, NORM,  0, 0);
        cyc("im_fwd",    0, NOP,            0, 1, 1, NORM,  1, 0);
        // Reset in the middle of a data stall
        cyc("rs_lw",     0, lw(18, 17),   0, 1, 1, NORM, 0, 0);
        cyc("rs_fwd2",   0, NOP,          0, 1, 1, NORM, 2, 0);
        chk_perf = 1'b1; p_luse = 1; p_dst = 5; p_fl = 2;
        cyc("rs_stall",  0, NOP,          0, 1, 0, DST,  0, 0);
        cyc("rs_assert", 1, NOP,          0, 1, 0, RSTV, 0, 0);
        chk_perf = 1'b1; p_luse = 0; p_dst = 0; p_fl = 0;
        cyc("rs_clear",  0, alu(21, 18, 17), 0, 1, 0, NORM, 0, 0);
        cyc("rs_next",   0, NOP,             0, 1, 0, NORM, 0, 0);

        begin : drain
            int budget;
            budget = 10;
            while (sb.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (sb.size() > 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drain_timeout: %0d entries left, want 0", sb.size());
            end
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
